// File: rtl/game_state_ctrl.sv
// Game phase sequencer: menu / playing / continue / final, with lives and level tracking.
// Phase changes are requested by events and committed only on a frame-start tick.
module game_state_ctrl #(
    parameter int LIVES_INIT     = 3,
    parameter int LIVES_BITS     = 2,
    parameter int MAX_LEVEL      = 4,
    parameter int LEVEL_BITS     = 3,
    parameter int CONT_FRAMES    = 120,
    parameter int FINAL_FRAMES   = 300,
    parameter int FRAME_CNT_BITS = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  frame_tick_i,
    input  logic                  start_btn_i,
    input  logic                  continue_btn_i,
    input  logic                  player_hit_i,
    input  logic                  level_clear_i,
    output logic                  is_menu_o,
    output logic                  is_playing_o,
    output logic                  is_continue_o,
    output logic                  is_final_o,
    output logic                  won_o,
    output logic [LIVES_BITS-1:0] lives_o,
    output logic [LEVEL_BITS-1:0] level_o,
    output logic                  state_change_o
);

    typedef enum logic [3:0] {
        ST_MENU  = 4'b0001,
        ST_PLAY  = 4'b0010,
        ST_CONT  = 4'b0100,
        ST_FINAL = 4'b1000
    } phase_e;

    localparam logic [FRAME_CNT_BITS-1:0] CONT_LAST   = FRAME_CNT_BITS'(CONT_FRAMES - 1);
    localparam logic [FRAME_CNT_BITS-1:0] FINAL_LAST  = FRAME_CNT_BITS'(FINAL_FRAMES - 1);
    localparam logic [LEVEL_BITS-1:0]     LAST_LEVEL  = LEVEL_BITS'(MAX_LEVEL);
    localparam logic [LIVES_BITS-1:0]     LIVES_START = LIVES_BITS'(LIVES_INIT);

    phase_e                      state_q, state_d;
    phase_e                      pend_state_q, pend_state_d;
    logic                        pend_vld_q, pend_vld_d;
    logic                        pend_won_q, pend_won_d;
    logic [FRAME_CNT_BITS-1:0]   frame_cnt_q, frame_cnt_d;
    logic [LIVES_BITS-1:0]       lives_q, lives_d;
    logic [LEVEL_BITS-1:0]       level_q, level_d;
    logic                        won_q, won_d;
    logic                        chg_q, chg_d;
    logic                        start_btn_q, cont_btn_q;

    logic start_edge_s, cont_edge_s, kill_s, hold_s, timeout_s, commit_s;
    logic game_start_s, next_level_s, lives_dec_s;

    assign start_edge_s = start_btn_i & ~start_btn_q;
    assign cont_edge_s  = continue_btn_i & ~cont_btn_q;
    assign kill_s       = player_hit_i & (lives_q == LIVES_BITS'(1));
    assign hold_s       = (state_q == ST_CONT) | (state_q == ST_FINAL);
    assign timeout_s    = ((state_q == ST_CONT)  & (frame_cnt_q == CONT_LAST)) |
                          ((state_q == ST_FINAL) & (frame_cnt_q == FINAL_LAST));

    // State, pending request, counters and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_MENU;
            pend_state_q <= ST_MENU;
            pend_vld_q   <= 1'b0;
            pend_won_q   <= 1'b0;
            frame_cnt_q  <= '0;
            lives_q      <= '0;
            level_q      <= '0;
            won_q        <= 1'b0;
            chg_q        <= 1'b0;
            start_btn_q  <= 1'b0;
            cont_btn_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_state_q <= pend_state_d;
            pend_vld_q   <= pend_vld_d;
            pend_won_q   <= pend_won_d;
            frame_cnt_q  <= frame_cnt_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            won_q        <= won_d;
            chg_q        <= chg_d;
            start_btn_q  <= start_btn_i;
            cont_btn_q   <= continue_btn_i;
        end
    end

    // Next phase: commit a pending request or a hold-screen timeout on a tick, else latch new requests.
    always_comb begin
        state_d      = state_q;
        pend_state_d = pend_state_q;
        pend_vld_d   = pend_vld_q;
        pend_won_d   = pend_won_q;
        frame_cnt_d  = frame_cnt_q;
        commit_s     = 1'b0;
        if (frame_tick_i && pend_vld_q) begin
            state_d     = pend_state_q;
            pend_vld_d  = 1'b0;
            frame_cnt_d = '0;
            commit_s    = 1'b1;
        end else if (frame_tick_i && timeout_s) begin
            state_d     = (state_q == ST_CONT) ? ST_PLAY : ST_MENU;
            frame_cnt_d = '0;
            commit_s    = 1'b1;
        end else begin
            if (frame_tick_i && hold_s && !pend_vld_q) begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_BITS'(1);
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
            if (!pend_vld_q) begin
                case (state_q)
                    ST_MENU: begin
                        pend_vld_d   = start_edge_s;
                        pend_state_d = ST_PLAY;
                        pend_won_d   = 1'b0;
                    end
                    ST_PLAY: begin
                        // A killing hit takes priority over a simultaneous clear.
                        if (kill_s) begin
                            pend_vld_d   = 1'b1;
                            pend_state_d = ST_FINAL;
                            pend_won_d   = 1'b0;
                        end else if (level_clear_i) begin
                            pend_vld_d   = 1'b1;
                            pend_state_d = (level_q == LAST_LEVEL) ? ST_FINAL : ST_CONT;
                            pend_won_d   = (level_q == LAST_LEVEL);
                        end else begin
                            pend_vld_d   = 1'b0;
                        end
                    end
                    ST_CONT: begin
                        pend_vld_d   = cont_edge_s;
                        pend_state_d = ST_PLAY;
                        pend_won_d   = 1'b0;
                    end
                    ST_FINAL: begin
                        pend_vld_d   = start_edge_s;
                        pend_state_d = ST_MENU;
                        pend_won_d   = 1'b0;
                    end
                    default: begin
                        pend_vld_d   = 1'b1;
                        pend_state_d = ST_MENU;
                        pend_won_d   = 1'b0;
                    end
                endcase
            end else begin
                pend_vld_d = pend_vld_q;
            end
        end
    end

    assign game_start_s = commit_s & (state_q == ST_MENU) & (state_d == ST_PLAY);
    assign next_level_s = commit_s & (state_q == ST_CONT) & (state_d == ST_PLAY);
    assign lives_dec_s  = (state_q == ST_PLAY) & player_hit_i & (lives_q != '0);

    // Lives, level, win flag and change pulse; score values persist through MENU until a new game.
    always_comb begin
        if (game_start_s) begin
            lives_d = LIVES_START;
        end else if (lives_dec_s) begin
            lives_d = lives_q - LIVES_BITS'(1);
        end else begin
            lives_d = lives_q;
        end
        if (game_start_s) begin
            level_d = LEVEL_BITS'(1);
        end else if (next_level_s) begin
            level_d = level_q + LEVEL_BITS'(1);
        end else begin
            level_d = level_q;
        end
        if (game_start_s) begin
            won_d = 1'b0;
        end else if (commit_s && state_d == ST_FINAL) begin
            won_d = pend_won_q;
        end else begin
            won_d = won_q;
        end
        chg_d = commit_s;
    end

    assign is_menu_o      = state_q[0];
    assign is_playing_o   = state_q[1];
    assign is_continue_o  = state_q[2];
    assign is_final_o     = state_q[3];
    assign won_o          = won_q;
    assign lives_o        = lives_q;
    assign level_o        = level_q;
    assign state_change_o = chg_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a rule-level reference model.
module tb_game_state_ctrl;

    localparam int LIVES_INIT   = 3;
    localparam int LIVES_BITS   = 2;
    localparam int MAX_LEVEL    = 4;
    localparam int LEVEL_BITS   = 3;
    localparam int CONT_FRAMES  = 3;
    localparam int FINAL_FRAMES = 2;
    localparam int P_MENU = 0, P_PLAY = 1, P_CONT = 2, P_FINAL = 3;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic frame_tick_i = 1'b0, start_btn_i = 1'b0, continue_btn_i = 1'b0;
    logic player_hit_i = 1'b0, level_clear_i = 1'b0;
    logic is_menu_o, is_playing_o, is_continue_o, is_final_o, won_o, state_change_o;
    logic [LIVES_BITS-1:0] lives_o;
    logic [LEVEL_BITS-1:0] level_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (m_*) and next-state (n_*)
    int m_phase, m_lives, m_level, m_cnt, m_pphase;
    bit m_pend, m_pwon, m_won, m_chg, m_sb, m_cb;
    int n_phase, n_lives, n_level, n_cnt, n_pphase;
    bit n_pend, n_pwon, n_won, n_chg, n_sb, n_cb;

    game_state_ctrl #(
        .LIVES_INIT(LIVES_INIT), .LIVES_BITS(LIVES_BITS), .MAX_LEVEL(MAX_LEVEL),
        .LEVEL_BITS(LEVEL_BITS), .CONT_FRAMES(CONT_FRAMES), .FINAL_FRAMES(FINAL_FRAMES),
        .FRAME_CNT_BITS(9)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .frame_tick_i(frame_tick_i),
        .start_btn_i(start_btn_i), .continue_btn_i(continue_btn_i),
        .player_hit_i(player_hit_i), .level_clear_i(level_clear_i),
        .is_menu_o(is_menu_o), .is_playing_o(is_playing_o),
        .is_continue_o(is_continue_o), .is_final_o(is_final_o),
        .won_o(won_o), .lives_o(lives_o), .level_o(level_o),
        .state_change_o(state_change_o)
    );

    always #5 clk_i = ~clk_i;

    // Phase flags must be one-hot whenever out of reset.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            n_tests++;
            if ($countones({is_menu_o, is_playing_o, is_continue_o, is_final_o}) != 1) begin
                n_fail++;
                $display("FAIL onehot: flags=%b required exactly one set",
                         {is_menu_o, is_playing_o, is_continue_o, is_final_o});
            end
        end
    end

    task automatic model_reset();
        m_phase = P_MENU; m_lives = 0; m_level = 0; m_cnt = 0; m_pphase = P_MENU;
        m_pend = 0; m_pwon = 0; m_won = 0; m_chg = 0; m_sb = 0; m_cb = 0;
    endtask

    task automatic model_enter(int target, bit w);
        n_chg = 1; n_phase = target; n_cnt = 0;
        if (target == P_PLAY && m_phase == P_MENU) begin
            n_lives = LIVES_INIT; n_level = 1; n_won = 0;
        end else if (target == P_PLAY) begin
            n_level = m_level + 1;
        end else if (target == P_FINAL) begin
            n_won = w;
        end
    endtask

    task automatic model_request(int target, bit w);
        n_pend = 1; n_pphase = target; n_pwon = w;
    endtask

    task automatic model_step();
        bit se, ce, done;
        n_phase = m_phase; n_lives = m_lives; n_level = m_level; n_cnt = m_cnt;
        n_pphase = m_pphase; n_pend = m_pend; n_pwon = m_pwon; n_won = m_won; n_chg = 0;
        se = start_btn_i && !m_sb;
        ce = continue_btn_i && !m_cb;
        n_sb = start_btn_i; n_cb = continue_btn_i;
        done = 0;
        if (frame_tick_i) begin
            if (m_pend) begin
                model_enter(m_pphase, m_pwon); n_pend = 0; done = 1;
            end else if (m_phase == P_CONT && m_cnt == CONT_FRAMES - 1) begin
                model_enter(P_PLAY, 0); done = 1;
            end else if (m_phase == P_FINAL && m_cnt == FINAL_FRAMES - 1) begin
                model_enter(P_MENU, 0); done = 1;
            end else if (m_phase == P_CONT || m_phase == P_FINAL) begin
                n_cnt = m_cnt + 1;
            end
        end
        if (!done && !m_pend) begin
            if (m_phase == P_MENU && se) model_request(P_PLAY, 0);
            else if (m_phase == P_PLAY && player_hit_i && m_lives == 1) model_request(P_FINAL, 0);
            else if (m_phase == P_PLAY && level_clear_i)
                model_request(m_level == MAX_LEVEL ? P_FINAL : P_CONT, m_level == MAX_LEVEL);
            else if (m_phase == P_CONT && ce) model_request(P_PLAY, 0);
            else if (m_phase == P_FINAL && se) model_request(P_MENU, 0);
        end
        if (m_phase == P_PLAY && player_hit_i && m_lives > 0) n_lives = m_lives - 1;
    endtask

    task automatic tick_cycle();
        model_step();
        @(posedge clk_i);
        #1;
        m_phase = n_phase; m_lives = n_lives; m_level = n_level; m_cnt = n_cnt;
        m_pphase = n_pphase; m_pend = n_pend; m_pwon = n_pwon; m_won = n_won;
        m_chg = n_chg; m_sb = n_sb; m_cb = n_cb;
    endtask

    task automatic pulse_tick();
        frame_tick_i = 1; tick_cycle(); frame_tick_i = 0; tick_cycle();
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_tests++;
        if ({is_menu_o, is_playing_o, is_continue_o, is_final_o} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 1000",
                               {is_menu_o, is_playing_o, is_continue_o, is_final_o});
        end
        n_tests++;
        if ({won_o, lives_o, level_o, state_change_o} !== 7'd0) begin
            n_fail++; $display("FAIL reset_values: won=%b lives=%0d level=%0d chg=%b want all 0",
                               won_o, lives_o, level_o, state_change_o);
        end
        @(posedge clk_i); #3 rst_ni = 1;
        tick_cycle();
    endtask

    task automatic test_start();
        int pulses = 0;
        for (int i = 0; i < 116; i++) begin
            start_btn_i  = (i >= 10 && i < 110);
            frame_tick_i = (i == 20 || i == 40);
            tick_cycle();
            if (state_change_o) pulses++;
            if (i == 19) begin
                n_tests++;
                if (is_menu_o !== 1'b1) begin
                    n_fail++; $display("FAIL start_before_tick: is_menu=%b want 1", is_menu_o);
                end
            end
            if (i == 20) begin
                n_tests++;
                if ({is_playing_o, state_change_o, lives_o, level_o} !== {1'b1, 1'b1, 2'd3, 3'd1}) begin
                    n_fail++; $display("FAIL start_commit: play=%b chg=%b lives=%0d level=%0d want 1 1 3 1",
                                       is_playing_o, state_change_o, lives_o, level_o);
                end
            end
        end
        frame_tick_i = 0; start_btn_i = 0;
        n_tests++;
        if (pulses != 1 || is_playing_o !== 1'b1) begin
            n_fail++; $display("FAIL start_held: pulses=%0d play=%b want 1 pulse, playing", pulses, is_playing_o);
        end
    endtask

    task automatic test_hit_clear();
        repeat (2) begin
            player_hit_i = 1; tick_cycle(); player_hit_i = 0; tick_cycle();
        end
        n_tests++;
        if (lives_o !== 2'd1 || is_playing_o !== 1'b1) begin
            n_fail++; $display("FAIL hit_decrement: lives=%0d play=%b want 1 1", lives_o, is_playing_o);
        end
        player_hit_i = 1; level_clear_i = 1; tick_cycle(); player_hit_i = 0; level_clear_i = 0;
        n_tests++;
        if (lives_o !== 2'd0 || is_playing_o !== 1'b1) begin
            n_fail++; $display("FAIL hit_clear_same: lives=%0d play=%b want 0 1", lives_o, is_playing_o);
        end
        frame_tick_i = 1; tick_cycle(); frame_tick_i = 0;
        n_tests++;
        if ({is_final_o, won_o, state_change_o} !== 3'b101) begin
            n_fail++; $display("FAIL kill_final: final=%b won=%b chg=%b want 1 0 1",
                               is_final_o, won_o, state_change_o);
        end
        pulse_tick();
        n_tests++;
        if (is_final_o !== 1'b1) begin
            n_fail++; $display("FAIL final_hold: final=%b want 1", is_final_o);
        end
        pulse_tick();
        n_tests++;
        if ({is_menu_o, lives_o, level_o, won_o} !== {1'b1, 2'd0, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL final_timeout: menu=%b lives=%0d level=%0d won=%b want 1 0 1 0",
                               is_menu_o, lives_o, level_o, won_o);
        end
    endtask

    task automatic test_same_cycle();
        start_btn_i = 1; frame_tick_i = 1; tick_cycle(); frame_tick_i = 0; tick_cycle();
        start_btn_i = 0;
        n_tests++;
        if (is_menu_o !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle_no_commit: menu=%b want 1", is_menu_o);
        end
        pulse_tick();
        n_tests++;
        if ({is_playing_o, lives_o, level_o} !== {1'b1, 2'd3, 3'd1}) begin
            n_fail++; $display("FAIL same_cycle_next_tick: play=%b lives=%0d level=%0d want 1 3 1",
                               is_playing_o, lives_o, level_o);
        end
    endtask

    task automatic test_continue();
        level_clear_i = 1; tick_cycle(); level_clear_i = 0;
        pulse_tick();
        n_tests++;
        if (is_continue_o !== 1'b1 || level_o !== 3'd1) begin
            n_fail++; $display("FAIL cont_enter: cont=%b level=%0d want 1 1", is_continue_o, level_o);
        end
        pulse_tick(); pulse_tick();
        n_tests++;
        if (is_continue_o !== 1'b1) begin
            n_fail++; $display("FAIL cont_hold: cont=%b want 1 after 2 ticks", is_continue_o);
        end
        pulse_tick();
        n_tests++;
        if ({is_playing_o, level_o, lives_o} !== {1'b1, 3'd2, 2'd3}) begin
            n_fail++; $display("FAIL cont_timeout: play=%b level=%0d lives=%0d want 1 2 3",
                               is_playing_o, level_o, lives_o);
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) begin
            player_hit_i = 1; tick_cycle(); player_hit_i = 0; tick_cycle();
        end
        n_tests++;
        if (lives_o !== 2'd1 || level_o !== 3'd2) begin
            n_fail++; $display("FAIL mid_setup: lives=%0d level=%0d want 1 2", lives_o, level_o);
        end
        #2 rst_ni = 0;
        #1;
        n_tests++;
        if ({is_menu_o, lives_o, level_o, state_change_o} !== {1'b1, 2'd0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL mid_reset: menu=%b lives=%0d level=%0d chg=%b want 1 0 0 0",
                               is_menu_o, lives_o, level_o, state_change_o);
        end
        model_reset();
        @(posedge clk_i); #3 rst_ni = 1;
        repeat (3) begin
            tick_cycle();
            n_tests++;
            if (state_change_o !== 1'b0 || is_menu_o !== 1'b1) begin
                n_fail++; $display("FAIL mid_reset_pulse: chg=%b menu=%b want 0 1", state_change_o, is_menu_o);
            end
        end
    endtask

    task automatic test_win();
        start_btn_i = 1; tick_cycle(); start_btn_i = 0; pulse_tick();
        repeat (3) begin
            level_clear_i = 1; tick_cycle(); level_clear_i = 0; pulse_tick();
            continue_btn_i = 1; tick_cycle(); continue_btn_i = 0; pulse_tick();
        end
        n_tests++;
        if (is_playing_o !== 1'b1 || level_o !== 3'd4) begin
            n_fail++; $display("FAIL win_reach_max: play=%b level=%0d want 1 4", is_playing_o, level_o);
        end
        level_clear_i = 1; tick_cycle(); level_clear_i = 0; pulse_tick();
        n_tests++;
        if (is_final_o !== 1'b1 || won_o !== 1'b1) begin
            n_fail++; $display("FAIL win_final: final=%b won=%b want 1 1", is_final_o, won_o);
        end
        pulse_tick(); pulse_tick();
        n_tests++;
        if ({is_menu_o, lives_o, level_o, won_o} !== {1'b1, 2'd3, 3'd4, 1'b1}) begin
            n_fail++; $display("FAIL win_score_hold: menu=%b lives=%0d level=%0d won=%b want 1 3 4 1",
                               is_menu_o, lives_o, level_o, won_o);
        end
        start_btn_i = 1; tick_cycle(); start_btn_i = 0; pulse_tick();
        n_tests++;
        if ({is_playing_o, lives_o, level_o, won_o} !== {1'b1, 2'd3, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL win_restart: play=%b lives=%0d level=%0d won=%b want 1 3 1 0",
                               is_playing_o, lives_o, level_o, won_o);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_flags;
        logic [3:0] one_hot_top;
        one_hot_top = 4'b1000;
        #2 rst_ni = 0;
        model_reset();
        @(posedge clk_i); #3 rst_ni = 1;
        for (int i = 0; i < 4000; i++) begin
            frame_tick_i   = ($urandom % 6) == 0;
            player_hit_i   = ($urandom % 15) == 0;
            level_clear_i  = ($urandom % 10) == 0;
            if (($urandom % 8) == 0) start_btn_i = ~start_btn_i;
            if (($urandom % 8) == 0) continue_btn_i = ~continue_btn_i;
            tick_cycle();
            exp_flags = one_hot_top >> m_phase;
            n_tests++;
            if ({is_menu_o, is_playing_o, is_continue_o, is_final_o} !== exp_flags) begin
                n_fail++; $display("FAIL rnd_phase cyc %0d: got %b want %b", i,
                                   {is_menu_o, is_playing_o, is_continue_o, is_final_o}, exp_flags);
            end
            n_tests++;
            if (lives_o !== m_lives[1:0] || level_o !== m_level[2:0] || won_o !== m_won) begin
                n_fail++; $display("FAIL rnd_score cyc %0d: lives=%0d level=%0d won=%b want %0d %0d %b",
                                   i, lives_o, level_o, won_o, m_lives, m_level, m_won);
            end
            n_tests++;
            if (state_change_o !== m_chg) begin
                n_fail++; $display("FAIL rnd_change cyc %0d: chg=%b want %b", i, state_change_o, m_chg);
            end
        end
        frame_tick_i = 0; player_hit_i = 0; level_clear_i = 0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit_clear();
        test_same_cycle();
        test_continue();
        test_reset_mid();
        test_win();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
